// File: rtl/allophone_rx.sv
// allophone_rx
//   Receives allophone codes from the host load handshake and queues them
//   for the Speech256 controller. The host drives data_in and pulses
//   data_stb. The block raises ldq when it can take a code. Codes are
//   buffered in a small first-word-fall-through FIFO. The FIFO is drained
//   through a valid/ready pair.
//
// Ports
//   clk         core clock
//   rst         synchronous active-high reset
//   data_in     6-bit allophone code from the host
//   data_stb    host load strobe; only a rising edge loads a code
//   ldq         registered; high when a new code can be accepted
//   allo_out    FIFO head code (first-word fall-through)
//   allo_valid  FIFO not empty
//   allo_ready  controller consumes the head code this cycle
//   level       FIFO occupancy 0..DEPTH (only with ALLO_RX_LEVEL_EN)
//
// Build option
//   ALLO_RX_LEVEL_EN  when defined, adds the registered `level` output.
module allophone_rx #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    data_in,
  input  logic          data_stb,
  output logic          ldq,
  output logic [5:0]    allo_out,
  output logic          allo_valid,
  input  logic          allo_ready
`ifdef ALLO_RX_LEVEL_EN
  ,
  output logic [AW:0]   level
`endif
);

  typedef enum logic [1:0] {
    S_READY = 2'b01,
    S_ACK   = 2'b10
  } state_t;

  state_t        state_reg, state_next;
  logic          ldq_reg, ldq_next;
  logic          stb_q_reg;
  logic [AW:0]   wptr_reg, wptr_next;
  logic [AW:0]   rptr_reg, rptr_next;
  logic [5:0]    out_reg, out_next;
  logic [5:0]    mem_reg [DEPTH];

  logic          push;
  logic          pop;
  logic          full_next;
  logic [AW:0]   count;
  logic [AW-1:0] rd_next_idx;

  // Only a fresh rising edge of the strobe loads a code. stb_q_reg resets
  // high, so a strobe held through reset has to drop first.
  assign push = data_stb & ~stb_q_reg & ldq_reg;
  assign pop  = allo_valid & allo_ready;

  assign count       = wptr_reg - rptr_reg;
  assign rd_next_idx = rptr_reg[AW-1:0] + AW'(1);

  assign wptr_next = push ? wptr_reg + (AW+1)'(1) : wptr_reg;
  assign rptr_next = pop  ? rptr_reg + (AW+1)'(1) : rptr_reg;

  // Full when the wrap bits differ and the index bits match.
  assign full_next = (wptr_next[AW] != rptr_next[AW]) &&
                     (wptr_next[AW-1:0] == rptr_next[AW-1:0]);

  // Head register. It tracks the code at the FIFO head so allo_out is
  // never X. When the FIFO drains, it keeps the last popped code.
  always_comb begin
    out_next = out_reg;
    if (pop) begin
      if (count == (AW+1)'(1)) begin
        // The only entry leaves. A simultaneous push becomes the new head.
        if (push) out_next = data_in;
      end else begin
        out_next = mem_reg[rd_next_idx];
      end
    end else if (push && !allo_valid) begin
      out_next = data_in;
    end
  end

  // Handshake FSM. The ldq_next value is what ldq shows after the edge.
  always_comb begin
    state_next = state_reg;
    ldq_next   = ~full_next;
    case (state_reg)
      S_READY: begin
        if (push) begin
          state_next = S_ACK;
          ldq_next   = 1'b0;
        end
      end
      S_ACK: begin
        if (data_stb) begin
          ldq_next = 1'b0;
        end else begin
          state_next = S_READY;
        end
      end
      default: state_next = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_READY;
      ldq_reg   <= 1'b1;
      stb_q_reg <= 1'b1;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ldq_reg   <= ldq_next;
      stb_q_reg <= data_stb;
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      out_reg   <= out_next;
    end
  end

  // Storage array, no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wptr_reg[AW-1:0]] <= data_in;
  end

  assign ldq        = ldq_reg;
  assign allo_valid = (wptr_reg != rptr_reg);
  assign allo_out   = out_reg;

`ifdef ALLO_RX_LEVEL_EN
  logic [AW:0] level_reg;

  always_ff @(posedge clk) begin
    if (rst) level_reg <= '0;
    else     level_reg <= wptr_next - rptr_next;
  end

  assign level = level_reg;
`endif

endmodule
